// File: rtl/clint_multi.sv
// clint_multi: AHB-Lite core-local interruptor with a shared prescaled 64-bit
// mtime, per-hart msip/mtimecmp, and a two-cycle ERROR response path.

// Per-hart state: software interrupt bit, compare register, timer interrupt.
module clint_multi_hart (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        msip_we,
    input  logic        cmp_lo_we,
    input  logic        cmp_hi_we,
    input  logic [31:0] wdata,
    input  logic [63:0] mtime,
    output logic        msip,
    output logic [63:0] mtimecmp,
    output logic        timer_int
);
    // bus-written msip bit and compare halves
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
        end else begin
            if (msip_we)   msip            <= wdata[0];
            if (cmp_lo_we) mtimecmp[31:0]  <= wdata;
            if (cmp_hi_we) mtimecmp[63:32] <= wdata;
        end
    end

    // registered unsigned compare against the registered mtime
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) timer_int <= 1'b0;
        else        timer_int <= (mtime >= mtimecmp);
    end
endmodule

module clint_multi #(
    parameter logic [31:0] BASE_ADDRESS = 32'h80050000,
    parameter int          NUM_HARTS    = 1,
    parameter int          PRESCALE     = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 HSEL,
    input  logic                 HREADY,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [31:0]          HADDR,
    input  logic [31:0]          HWDATA,
    output logic [31:0]          HRDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [NUM_HARTS-1:0] timer_int,
    output logic [NUM_HARTS-1:0] soft_int
);
    localparam logic [0:0]  S_OKAY    = 1'b0;
    localparam logic [0:0]  S_ERR1    = 1'b1;
    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    logic        state;
    logic        dp_valid, dp_write, dp_inwin;
    logic [9:0]  dp_off;
    logic [2:0]  dp_size;
    logic [63:0] mtime;
    logic [15:0] presc;
    logic [31:0] snap;
    logic [31:0] rd_mux;
    logic        sel_msip, sel_mtlo, sel_mthi, sel_snap, sel_cmp;
    logic        legal, acc_ok, err_start, wr_en, rd_en;
    logic [5:0]  msip_idx;
    logic [4:0]  cmp_idx;

    logic [NUM_HARTS-1:0]       msip_vec;
    logic [NUM_HARTS-1:0][63:0] cmp_vec;

    // SEQ/NONSEQ is all that matters; the low transfer-type bit is not needed
    logic unused_htrans;
    assign unused_htrans = HTRANS[0];

    wire cap = HSEL & HREADY & HTRANS[1];

    // address-phase capture; a non-captured cycle becomes an idle data phase
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_inwin <= 1'b0;
            dp_off   <= '0;
            dp_size  <= '0;
        end else begin
            dp_valid <= cap;
            if (cap) begin
                dp_write <= HWRITE;
                dp_inwin <= (HADDR[31:10] == BASE_ADDRESS[31:10]);
                dp_off   <= HADDR[9:0];
                dp_size  <= HSIZE;
            end
        end
    end

    assign msip_idx = dp_off[7:2];
    assign cmp_idx  = dp_off[7:3];

    // decode the captured offset into register selects
    always_comb begin
        sel_msip = 1'b0;
        sel_mtlo = 1'b0;
        sel_mthi = 1'b0;
        sel_snap = 1'b0;
        sel_cmp  = 1'b0;
        case (dp_off[9:8])
            2'd0: sel_msip = (int'(msip_idx) < NUM_HARTS);
            2'd1: begin
                sel_mtlo = (dp_off[7:0] == 8'h00);
                sel_mthi = (dp_off[7:0] == 8'h04);
                sel_snap = (dp_off[7:0] == 8'h08);
            end
            2'd2: sel_cmp = (int'(cmp_idx) < NUM_HARTS);
            default: ;
        endcase
    end

    // the snapshot is read-only; writing it is an error like any unmapped access
    assign legal     = dp_valid & dp_inwin & (dp_size == 3'b010) & (dp_off[1:0] == 2'b00)
                     & (sel_msip | sel_mtlo | sel_mthi | sel_snap | sel_cmp)
                     & ~(dp_write & sel_snap);
    assign acc_ok    = legal & (state == S_OKAY);
    assign err_start = dp_valid & ~legal & (state == S_OKAY);
    assign wr_en     = acc_ok & dp_write;
    assign rd_en     = acc_ok & ~dp_write;

    // two-cycle ERROR: first cycle stalls, second completes with HRESP still high
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                 state <= S_OKAY;
        else if (state == S_ERR1)   state <= S_OKAY;
        else if (err_start)         state <= S_ERR1;
    end

    assign HREADYOUT = ~err_start;
    assign HRESP     = err_start | (state == S_ERR1);

    // prescaled mtime; a bus write to either half drops that cycle's tick
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mtime <= '0;
            presc <= '0;
        end else if (wr_en & (sel_mtlo | sel_mthi)) begin
            presc <= '0;
            if (sel_mtlo) mtime[31:0]  <= HWDATA;
            if (sel_mthi) mtime[63:32] <= HWDATA;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            mtime <= mtime + 64'd1;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // reading mtime low latches the matching high word for a carry-safe pair
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                 snap <= '0;
        else if (rd_en & sel_mtlo)  snap <= mtime[63:32];
    end

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        clint_multi_hart u_hart (
            .clk       (clk),
            .n_rst     (n_rst),
            .msip_we   (wr_en & sel_msip & (msip_idx == 6'(h))),
            .cmp_lo_we (wr_en & sel_cmp & (cmp_idx == 5'(h)) & ~dp_off[2]),
            .cmp_hi_we (wr_en & sel_cmp & (cmp_idx == 5'(h)) &  dp_off[2]),
            .wdata     (HWDATA),
            .mtime     (mtime),
            .msip      (msip_vec[h]),
            .mtimecmp  (cmp_vec[h]),
            .timer_int (timer_int[h])
        );
    end

    assign soft_int = msip_vec;

    // read mux over the captured offset and current register contents
    always_comb begin
        rd_mux = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (sel_msip && int'(msip_idx) == h) rd_mux = {31'd0, msip_vec[h]};
            if (sel_cmp && int'(cmp_idx) == h)
                rd_mux = dp_off[2] ? cmp_vec[h][63:32] : cmp_vec[h][31:0];
        end
        if (sel_mtlo) rd_mux = mtime[31:0];
        if (sel_mthi) rd_mux = mtime[63:32];
        if (sel_snap) rd_mux = snap;
    end

    assign HRDATA = rd_en ? rd_mux : 32'd0;
endmodule
